// File: rtl/keypad_pkg.sv
// Shared matrix geometry, scan column state encoding and key numbering.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = 15;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_state_t;

  function automatic int key_index(input int col, input int row);
    return col * NUM_ROWS + row;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Matrix pins and debounced key outputs of the keypad scanner.
interface keypad_scanner_if;
  logic [keypad_pkg::NUM_ROWS-1:0] row_i;
  logic [keypad_pkg::NUM_COLS-1:0] col_o;
  logic [keypad_pkg::NUM_KEYS-1:0] keypad_o;
  logic                            key_change;
  logic                            frame_done;

  modport master (output row_i, input col_o, keypad_o, key_change, frame_done);
  modport slave  (input row_i, output col_o, keypad_o, key_change, frame_done);
endinterface

// File: rtl/key_debounce.sv
// Per-key integrating debouncer: stable flips after DB_SCANS consecutive disagreeing samples.
module key_debounce #(
  parameter int DB_SCANS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic raw,
  output logic stable,
  output logic toggled
);
  localparam int CW = $clog2(DB_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_SCANS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          toggled_q, toggled_d;

  always_comb begin
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    toggled_d = 1'b0;
    if (sample_en) begin
      if (raw == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        // the increment would reach DB_SCANS: commit the new level
        stable_d  = ~stable_q;
        cnt_d     = '0;
        toggled_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      toggled_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      toggled_q <= toggled_d;
    end
  end

  assign stable  = stable_q;
  assign toggled = toggled_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix scanner: column drive, row synchroniser, per-key debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES = 3000,
  parameter int DB_SCANS    = 8
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.slave   bus
);
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);

  col_state_t              state_q, state_d;
  logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [NUM_COLS-1:0]     col_q, col_d;
  logic [NUM_ROWS-1:0]     sync1_q, sync2_q;
  logic                    frame_done_q;
  logic                    sample_pt;
  logic [NUM_ROWS-1:0]     pressed;
  logic [NUM_KEYS-1:0]     stable;
  logic [NUM_KEYS-1:0]     toggled;

  assign sample_pt = (slot_cnt_q == SLOT_LAST);
  assign pressed   = ~sync2_q;

  always_comb begin
    slot_cnt_d = sample_pt ? '0 : slot_cnt_q + SW'(1);
    state_d    = sample_pt ? col_state_t'(state_q + 2'd1) : state_q;
    col_d      = ~(4'b0001 << state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COL0;
      slot_cnt_q   <= '0;
      col_q        <= 4'b1110;
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      col_q        <= col_d;
      sync1_q      <= bus.row_i;
      sync2_q      <= sync1_q;
      frame_done_q <= sample_pt && (state_q == COL3);
    end
  end

  // Matrix position 15 maps past NUM_KEYS and gets no debouncer.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    localparam logic [1:0] CI = 2'(c);
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      localparam int K = key_index(c, r);
      if (K < NUM_KEYS) begin : g_key
        key_debounce #(.DB_SCANS(DB_SCANS)) u_db (
          .clk       (clk),
          .reset     (reset),
          .sample_en (sample_pt && (state_q == col_state_t'(CI))),
          .raw       (pressed[r]),
          .stable    (stable[K]),
          .toggled   (toggled[K])
        );
      end
    end
  end

  assign bus.col_o      = col_q;
  assign bus.keypad_o   = stable;
  assign bus.key_change = |toggled;
  assign bus.frame_done = frame_done_q;
endmodule
